light_manager_mc: RTL and testbench

//  Multi-channel successor of the single-channel light manager. Holds NUM_CH brightness targets.

---
 rtl/light_manager_mc.sv | 177 +++++++++++++++++
 tb/tb_light_manager_mc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_manager_mc.sv
// -----------------------------------------------------------------------------
// light_manager_mc
//   Multi-channel LED brightness manager. Keeps one brightness target per
//   channel. Encoder inc/dec pulses move the target of the selected channel
//   by STEP, saturating at 0 and MAX. A next_ch pulse advances the selection.
//   Each channel's level ramps one LSB per ramp tick toward its target and
//   drives its own PWM output. The PWM duty is shadowed at period boundaries
//   so an output never glitches mid-period.
//
// Ports
//   clk_i      in   1        clock, rising edge
//   rst_n_i    in   1        asynchronous active-low reset
//   inc_i      in   1        pulse: raise target of selected channel by STEP
//   dec_i      in   1        pulse: lower target of selected channel by STEP
//   next_ch_i  in   1        pulse: select next channel (wraps)
//   all_off_i  in   1        pulse: set every target to 0
//   pwm_o      out  NUM_CH   registered PWM, one bit per channel
//   ch_sel_o   out  CH_W     selected channel (registered)
//   target_o   out  VALUE_W  target of the selected channel (mux of registers)
//   busy_o     out  1        registered; 1 while any level differs from target
// -----------------------------------------------------------------------------
module light_manager_mc #(
  parameter  int NUM_CH   = 4,
  parameter  int VALUE_W  = 8,
  parameter  int STEP     = 5,
  parameter  int RAMP_DIV = 1000,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               next_ch_i,
  input  logic               all_off_i,
  output logic [NUM_CH-1:0]  pwm_o,
  output logic [CH_W-1:0]    ch_sel_o,
  output logic [VALUE_W-1:0] target_o,
  output logic               busy_o
);

  localparam int MAX     = 2**VALUE_W - 1;
  localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef logic [VALUE_W-1:0] value_t;
  // One extra bit so MAX-STEP and target+STEP compare without wrapping.
  typedef logic [VALUE_W:0]   wide_t;
  typedef logic [PRESC_W-1:0] presc_t;
  typedef logic [CH_W-1:0]    ch_t;

  localparam wide_t  MAX_W      = wide_t'(MAX);
  localparam wide_t  STEP_W     = wide_t'(STEP);
  localparam value_t MAX_V      = value_t'(MAX);
  localparam presc_t PRESC_LAST = presc_t'(RAMP_DIV - 1);
  localparam ch_t    CH_LAST    = ch_t'(NUM_CH - 1);

  // ---------------------------------------------------------------------------
  // Saturating arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic value_t sat_inc(input value_t v);
    wide_t w;
    w = {1'b0, v};
    if (w > MAX_W - STEP_W) return MAX_V;
    else                    return value_t'(w + STEP_W);
  endfunction

  function automatic value_t sat_dec(input value_t v);
    wide_t w;
    w = {1'b0, v};
    if (w < STEP_W) return '0;
    else            return value_t'(w - STEP_W);
  endfunction

  function automatic value_t step_toward(input value_t lvl, input value_t tgt);
    if (lvl < tgt)      return lvl + value_t'(1);
    else if (lvl > tgt) return lvl - value_t'(1);
    else                return lvl;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  value_t            target_q [NUM_CH];
  value_t            target_d [NUM_CH];
  value_t            level_q  [NUM_CH];
  value_t            level_d  [NUM_CH];
  value_t            duty_q   [NUM_CH];
  value_t            duty_d   [NUM_CH];
  value_t            cnt_q;
  presc_t            presc_q;
  presc_t            presc_d;
  ch_t               ch_sel_q;
  ch_t               ch_sel_d;
  logic [NUM_CH-1:0] pwm_q;
  logic [NUM_CH-1:0] pwm_d;
  logic              busy_q;
  logic              busy_d;
  logic              tick;
  logic              period_end;

  assign tick       = (presc_q == PRESC_LAST);
  assign period_end = (cnt_q == MAX_V);

  // ---------------------------------------------------------------------------
  // Target update and channel select
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a full default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    target_d = target_q;
    if (all_off_i) begin
      for (int k = 0; k < NUM_CH; k++) target_d[k] = '0;
    end else if (inc_i && !dec_i) begin
      target_d[ch_sel_q] = sat_inc(target_q[ch_sel_q]);
    end else if (dec_i && !inc_i) begin
      target_d[ch_sel_q] = sat_dec(target_q[ch_sel_q]);
    end
  end

  always_comb begin
    ch_sel_d = ch_sel_q;
    if (next_ch_i) ch_sel_d = (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + ch_t'(1);
  end

  // ---------------------------------------------------------------------------
  // Ramp, duty shadow, PWM compare and busy flag
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = tick ? '0 : presc_q + presc_t'(1);
    level_d = level_q;
    duty_d  = duty_q;
    pwm_d   = '0;
    busy_d  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tick)       level_d[k] = step_toward(level_q[k], target_q[k]);
      // Duty only follows the level on the last count of a period.
      if (period_end) duty_d[k]  = level_q[k];
      pwm_d[k] = (cnt_q < duty_q[k]);
      if (level_q[k] != target_q[k]) busy_d = 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the per-channel arrays are plain flops whose values are visible
      // on the outputs, so every entry is cleared rather than left undefined.
      for (int k = 0; k < NUM_CH; k++) begin
        target_q[k] <= '0;
        level_q[k]  <= '0;
        duty_q[k]   <= '0;
      end
      cnt_q    <= '0;
      presc_q  <= '0;
      ch_sel_q <= '0;
      pwm_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        target_q[k] <= target_d[k];
        level_q[k]  <= level_d[k];
        duty_q[k]   <= duty_d[k];
      end
      cnt_q    <= cnt_q + value_t'(1);
      presc_q  <= presc_d;
      ch_sel_q <= ch_sel_d;
      pwm_q    <= pwm_d;
      busy_q   <= busy_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign ch_sel_o = ch_sel_q;
  assign target_o = target_q[ch_sel_q];
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_light_manager_mc.sv
// -----------------------------------------------------------------------------
// tb_light_manager_mc
//   Self-checking bench for light_manager_mc (NUM_CH=4, VALUE_W=8, STEP=5,
//   RAMP_DIV=4). Scenario tasks plus a randomized run compared against a
//   behavioural model built from integer targets, levels and duty shadows.
// -----------------------------------------------------------------------------
module tb_light_manager_mc;

  localparam int NUM_CH = 4;
  localparam int VW     = 8;
  localparam int MAX    = 255;
  localparam int STEP   = 5;
  localparam int RD     = 4;

  logic              clk;
  logic              rst_n;
  logic              inc;
  logic              dec;
  logic              next_ch;
  logic              all_off;
  logic [NUM_CH-1:0] pwm;
  logic [1:0]        ch_sel;
  logic [VW-1:0]     target;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  light_manager_mc #(
    .NUM_CH  (NUM_CH),
    .VALUE_W (VW),
    .STEP    (STEP),
    .RAMP_DIV(RD)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .inc_i    (inc),
    .dec_i    (dec),
    .next_ch_i(next_ch),
    .all_off_i(all_off),
    .pwm_o    (pwm),
    .ch_sel_o (ch_sel),
    .target_o (target),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: integer state, updated once per rising edge
  // ---------------------------------------------------------------------------
  int          m_tgt [NUM_CH];
  int          m_lvl [NUM_CH];
  int          m_dty [NUM_CH];
  int          m_cnt;
  int          m_presc;
  int          m_sel;
  logic [3:0]  m_pwm;
  logic        m_busy;

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_tgt[k] = 0; m_lvl[k] = 0; m_dty[k] = 0;
    end
    m_cnt = 0; m_presc = 0; m_sel = 0; m_pwm = '0; m_busy = 1'b0;
  endtask

  task automatic model_edge(input bit i, input bit d, input bit n, input bit o);
    int nt [NUM_CH];
    int nl [NUM_CH];
    int nd [NUM_CH];
    bit tick;
    tick = (m_presc == RD - 1);
    m_busy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      nt[k] = o ? 0 : m_tgt[k];
      nl[k] = m_lvl[k];
      if (tick && m_tgt[k] > m_lvl[k]) nl[k] = m_lvl[k] + 1;
      if (tick && m_tgt[k] < m_lvl[k]) nl[k] = m_lvl[k] - 1;
      nd[k] = (m_cnt == MAX) ? m_lvl[k] : m_dty[k];
      m_pwm[k] = (m_cnt < m_dty[k]);
      if (m_lvl[k] != m_tgt[k]) m_busy = 1'b1;
    end
    if (!o && i && !d) nt[m_sel] = (m_tgt[m_sel] + STEP > MAX) ? MAX : m_tgt[m_sel] + STEP;
    if (!o && d && !i) nt[m_sel] = (m_tgt[m_sel] - STEP < 0) ? 0 : m_tgt[m_sel] - STEP;
    for (int k = 0; k < NUM_CH; k++) begin
      m_tgt[k] = nt[k]; m_lvl[k] = nl[k]; m_dty[k] = nd[k];
    end
    if (n) m_sel = (m_sel + 1) % NUM_CH;
    m_cnt   = (m_cnt + 1) % (MAX + 1);
    m_presc = (m_presc + 1) % RD;
  endtask

  // Drive one cycle of pulses (entered ~1 time unit after a rising edge) and
  // return 1 time unit after the next rising edge with the model advanced.
  task automatic cycle(input bit i, input bit d, input bit n, input bit o);
    inc = i; dec = d; next_ch = n; all_off = o;
    @(posedge clk);
    model_edge(i, d, n, o);
    #1;
    inc = 1'b0; dec = 1'b0; next_ch = 1'b0; all_off = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; inc = 1'b0; dec = 1'b0; next_ch = 1'b0; all_off = 1'b0;
    #3;
    checks += 4;
    if (pwm !== 4'h0)    begin failures++; $display("FAIL reset_pwm got=%h exp=0", pwm); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (ch_sel !== 2'd0) begin failures++; $display("FAIL reset_ch_sel got=%0d exp=0", ch_sel); end
    if (target !== 8'd0) begin failures++; $display("FAIL reset_target got=%0d exp=0", target); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    int n;
    int highs;
    bit done;
    repeat (3) cycle(1, 0, 0, 0);
    checks++;
    if (target !== 8'd15) begin failures++; $display("FAIL ramp_target got=%0d exp=15", target); end
    cycle(0, 0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ramp_busy_rise got=%b exp=1", busy); end
    done = 1'b0; n = 0;
    while (!done && n < 200) begin
      cycle(0, 0, 0, 0);
      n++;
      checks++;
      if (busy !== m_busy) begin failures++; $display("FAIL ramp_busy cyc=%0d got=%b exp=%b", n, busy, m_busy); end
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done || n < 50 || n > 70) begin
      failures++; $display("FAIL ramp_duration got=%0d cycles exp=57..60 done=%b", n, done);
    end
    repeat (300) cycle(0, 0, 0, 0);
    highs = 0;
    for (int c = 0; c < 256; c++) begin
      cycle(0, 0, 0, 0);
      if (pwm[0]) highs++;
      checks++;
      if (pwm[3:1] !== 3'b000) begin failures++; $display("FAIL ramp_idle_pwm got=%b exp=000", pwm[3:1]); end
    end
    checks++;
    if (highs != 15) begin failures++; $display("FAIL ramp_duty got=%0d exp=15", highs); end
  endtask

  task automatic test_saturation();
    cycle(0, 0, 1, 0);
    repeat (50) cycle(1, 0, 0, 0);
    checks++;
    if (target !== 8'd250) begin failures++; $display("FAIL sat_250 got=%0d exp=250", target); end
    cycle(1, 0, 0, 0);
    checks++;
    if (target !== 8'd255) begin failures++; $display("FAIL sat_inc_clip got=%0d exp=255", target); end
    cycle(1, 0, 0, 0);
    checks++;
    if (target !== 8'd255) begin failures++; $display("FAIL sat_inc_hold got=%0d exp=255", target); end
    repeat (50) cycle(0, 1, 0, 0);
    checks++;
    if (target !== 8'd5) begin failures++; $display("FAIL sat_5 got=%0d exp=5", target); end
    cycle(0, 1, 0, 0);
    checks++;
    if (target !== 8'd0) begin failures++; $display("FAIL sat_dec_zero got=%0d exp=0", target); end
    cycle(0, 1, 0, 0);
    checks++;
    if (target !== 8'd0) begin failures++; $display("FAIL sat_dec_hold got=%0d exp=0", target); end
  endtask

  task automatic test_select();
    int exp_sel;
    exp_sel = 1;
    for (int p = 0; p < 4; p++) begin
      cycle(0, 0, 1, 0);
      exp_sel = (exp_sel == 3) ? 0 : exp_sel + 1;
      checks++;
      if (ch_sel !== 2'(exp_sel)) begin failures++; $display("FAIL sel_step%0d got=%0d exp=%0d", p, ch_sel, exp_sel); end
    end
    cycle(0, 0, 1, 0);   // now on channel 2
    cycle(1, 0, 1, 0);   // inc lands on channel 2, selection moves to 3
    checks += 2;
    if (ch_sel !== 2'd3) begin failures++; $display("FAIL sel_with_inc got=%0d exp=3", ch_sel); end
    if (target !== 8'd0) begin failures++; $display("FAIL sel_ch3_untouched got=%0d exp=0", target); end
    repeat (3) cycle(0, 0, 1, 0);
    checks++;
    if (target !== 8'd5) begin failures++; $display("FAIL sel_ch2_inc got=%0d exp=5", target); end
  endtask

  task automatic test_conflict();
    int n;
    bit done;
    cycle(1, 1, 0, 0);
    checks++;
    if (target !== 8'd5) begin failures++; $display("FAIL conflict_incdec got=%0d exp=5", target); end
    cycle(1, 0, 0, 1);
    checks++;
    if (target !== 8'd0) begin failures++; $display("FAIL conflict_alloff got=%0d exp=0", target); end
    done = 1'b0; n = 0;
    while (!done && n < 2000) begin
      cycle(0, 0, 0, 0);
      n++;
      checks += 2;
      if (busy !== m_busy) begin failures++; $display("FAIL conflict_busy cyc=%0d got=%b exp=%b", n, busy, m_busy); end
      if (pwm !== m_pwm)   begin failures++; $display("FAIL conflict_pwm cyc=%0d got=%h exp=%h", n, pwm, m_pwm); end
      if (!busy && n > 2) done = 1'b1;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL conflict_settle got=timeout exp=busy low"); end
  endtask

  task automatic test_pwm_edges();
    int n;
    int ones;
    int lows;
    bit done;
    while (m_sel != 0) cycle(0, 0, 1, 0);
    repeat (300) cycle(0, 0, 0, 0);
    ones = 0;
    for (int c = 0; c < 300; c++) begin
      cycle(0, 0, 0, 0);
      if (pwm !== 4'h0) ones++;
    end
    checks++;
    if (ones != 0) begin failures++; $display("FAIL pwm_zero got=%0d high cycles exp=0", ones); end
    repeat (52) cycle(1, 0, 0, 0);
    checks++;
    if (target !== 8'd255) begin failures++; $display("FAIL pwm_full_target got=%0d exp=255", target); end
    done = 1'b0; n = 0;
    while (!done && n < 1500) begin
      cycle(0, 0, 0, 0);
      n++;
      checks++;
      if (pwm !== m_pwm) begin failures++; $display("FAIL pwm_ramp cyc=%0d got=%h exp=%h", n, pwm, m_pwm); end
      if (!busy && n > 2) done = 1'b1;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL pwm_full_settle got=timeout exp=busy low"); end
    repeat (300) cycle(0, 0, 0, 0);
    lows = 0;
    for (int c = 0; c < 256; c++) begin
      cycle(0, 0, 0, 0);
      if (!pwm[0]) lows++;
    end
    checks++;
    if (lows != 1) begin failures++; $display("FAIL pwm_full_low got=%0d exp=1", lows); end
  endtask

  task automatic test_random();
    bit i, d, n, o;
    for (int c = 0; c < 3000; c++) begin
      i = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 6) == 0);
      n = ($urandom_range(0, 15) == 0);
      o = ($urandom_range(0, 199) == 0);
      cycle(i, d, n, o);
      checks += 4;
      if (pwm !== m_pwm)             begin failures++; $display("FAIL rand_pwm cyc=%0d got=%h exp=%h", c, pwm, m_pwm); end
      if (busy !== m_busy)           begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, m_busy); end
      if (ch_sel !== 2'(m_sel))      begin failures++; $display("FAIL rand_sel cyc=%0d got=%0d exp=%0d", c, ch_sel, m_sel); end
      if (target !== 8'(m_tgt[m_sel])) begin failures++; $display("FAIL rand_target cyc=%0d got=%0d exp=%0d", c, target, m_tgt[m_sel]); end
    end
  endtask

  task automatic test_async_reset();
    while (m_sel != 1) cycle(0, 0, 1, 0);
    repeat (10) cycle(1, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (pwm !== 4'h0)    begin failures++; $display("FAIL areset_pwm got=%h exp=0", pwm); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    if (ch_sel !== 2'd0) begin failures++; $display("FAIL areset_ch_sel got=%0d exp=0", ch_sel); end
    if (target !== 8'd0) begin failures++; $display("FAIL areset_target got=%0d exp=0", target); end
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    checks += 2;
    if (target !== 8'd5) begin failures++; $display("FAIL areset_inc got=%0d exp=5", target); end
    if (ch_sel !== 2'd0) begin failures++; $display("FAIL areset_sel got=%0d exp=0", ch_sel); end
    cycle(0, 0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL areset_busy_rise got=%b exp=1", busy); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_select();
    test_conflict();
    test_pwm_edges();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
